// File: rtl/spmm_pkg.sv
// Shared SpMM definitions: matrix geometry, element type and packer states.
package spmm_pkg;

  localparam int N     = 16;
  localparam int W     = 8;
  localparam int lgN   = $clog2(N);
  localparam int dbLgN = 2 * lgN;

  typedef logic [W-1:0] data_t;

  // COLLECT accepts dense rows, EMIT streams the CSR beats of one matrix.
  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } pk_state_e;

  // Element is stored in CSR form only when it is nonzero.
  function automatic logic is_nonzero(input data_t v);
    return (v != '0);
  endfunction

endpackage

// File: rtl/row_compactor.sv
// Combinational compaction of one dense row: nonzero values packed to the
// low slots in ascending column order, with their source columns and count.
module row_compactor #(
  parameter int N = 16,
  parameter int W = 8
) (
  input  logic [N-1:0][W-1:0]          i_row,
  output logic [N-1:0][W-1:0]          o_data,
  output logic [N-1:0][$clog2(N)-1:0]  o_col,
  output logic [$clog2(N):0]           o_cnt
);

  localparam int LGN = $clog2(N);

  // Walk the columns in order, appending each nonzero at the running count.
  always_comb begin
    logic [LGN:0] v_cnt;
    v_cnt  = '0;
    o_data = '0;
    o_col  = '0;
    for (int j = 0; j < N; j++) begin
      if (i_row[j] != '0) begin
        o_data[v_cnt[LGN-1:0]] = i_row[j];
        o_col[v_cnt[LGN-1:0]]  = LGN'(j);
        v_cnt                  = v_cnt + (LGN+1)'(1);
      end else begin
        v_cnt = v_cnt;
      end
    end
    o_cnt = v_cnt;
  end

endmodule

// File: rtl/csr_packer.sv
// Dense-to-CSR packer: collects N dense rows, then streams the matrix as
// beats of N nonzeros with row pointers and total nonzero count.
module csr_packer
  import spmm_pkg::*;
#(
  parameter int N = spmm_pkg::N,
  parameter int W = spmm_pkg::W
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             row_valid,
  output logic                             row_ready,
  input  logic [N-1:0][W-1:0]              row_data,
  output logic                             lhs_valid,
  input  logic                             lhs_ready,
  output logic                             lhs_start,
  output logic                             lhs_last,
  output logic [N-1:0][2*$clog2(N)-1:0]    lhs_ptr,
  output logic [N-1:0][$clog2(N)-1:0]      lhs_col,
  output logic [N-1:0][W-1:0]              lhs_data,
  output logic [2*$clog2(N):0]             lhs_nnz
);

  localparam int LGN   = $clog2(N);
  localparam int DBLGN = 2 * LGN;

  logic [N-1:0][W-1:0]   w_cmp_data;
  logic [N-1:0][LGN-1:0] w_cmp_col;
  logic [LGN:0]          w_cmp_cnt;

  row_compactor #(.N(N), .W(W)) u_row_compactor (
    .i_row  (row_data),
    .o_data (w_cmp_data),
    .o_col  (w_cmp_col),
    .o_cnt  (w_cmp_cnt)
  );

  pk_state_e               r_state;
  logic [LGN-1:0]          r_row;
  logic [DBLGN:0]          r_nnz;
  logic [LGN-1:0]          r_beat;
  logic                    r_row_ready;
  logic                    r_valid;
  logic                    r_start;
  logic                    r_last;
  logic [N-1:0][DBLGN-1:0] r_ptr;
  logic [W-1:0]            r_store_data [N*N];
  logic [LGN-1:0]          r_store_col  [N*N];

  logic                    w_row_fire;
  logic                    w_beat_fire;
  logic [DBLGN:0]          w_nnz_next;
  logic [DBLGN:0]          w_nnz_m1;
  logic [LGN-1:0]          w_last_beat;
  logic [DBLGN-1:0]        w_base;

  // r_row_ready is only ever 1 in COLLECT, so it alone qualifies a row transfer.
  assign w_row_fire  = row_valid && r_row_ready;
  assign w_beat_fire = r_valid && lhs_ready;
  assign w_nnz_next  = r_nnz + {{(DBLGN-LGN){1'b0}}, w_cmp_cnt};
  assign w_nnz_m1    = r_nnz - (DBLGN+1)'(1);
  // Index of the final beat; only consulted while nnz > N, so nnz-1 never wraps.
  assign w_last_beat = w_nnz_m1[DBLGN-1:LGN];
  assign w_base      = r_nnz[DBLGN-1:0];

  // Control FSM: row collection, beat sequencing and all handshake outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= COLLECT;
      r_row       <= '0;
      r_nnz       <= '0;
      r_beat      <= '0;
      r_row_ready <= 1'b0;
      r_valid     <= 1'b0;
      r_start     <= 1'b0;
      r_last      <= 1'b0;
      r_ptr       <= '0;
    end else begin
      case (r_state)
        COLLECT: begin
          r_row_ready <= 1'b1;
          if (w_row_fire) begin
            r_ptr[r_row] <= r_nnz[DBLGN-1:0];
            r_nnz        <= w_nnz_next;
            r_row        <= r_row + LGN'(1);
            if (r_row == LGN'(N-1)) begin
              r_state     <= EMIT;
              r_row_ready <= 1'b0;
              r_valid     <= 1'b1;
              r_start     <= 1'b1;
              r_last      <= (w_nnz_next <= (DBLGN+1)'(N));
              r_beat      <= '0;
            end
          end
        end
        EMIT: begin
          if (w_beat_fire) begin
            if (r_last) begin
              r_state     <= COLLECT;
              r_valid     <= 1'b0;
              r_start     <= 1'b0;
              r_last      <= 1'b0;
              r_row       <= '0;
              r_nnz       <= '0;
              r_beat      <= '0;
              r_row_ready <= 1'b1;
            end else begin
              r_beat  <= r_beat + LGN'(1);
              r_start <= 1'b0;
              r_last  <= ((r_beat + LGN'(1)) == w_last_beat);
            end
          end
        end
        default: begin
          r_state     <= COLLECT;
          r_row_ready <= 1'b0;
          r_valid     <= 1'b0;
          r_start     <= 1'b0;
          r_last      <= 1'b0;
        end
      endcase
    end
  end

  // Nonzero storage: append the compacted row at the running nnz offset.
  always_ff @(posedge clock) begin
    if (w_row_fire) begin
      for (int i = 0; i < N; i++) begin
        if ((LGN+1)'(i) < w_cmp_cnt) begin
          r_store_data[w_base + DBLGN'(i)] <= w_cmp_data[i];
          r_store_col[w_base + DBLGN'(i)]  <= w_cmp_col[i];
        end
      end
    end
  end

  // Beat read-out from registered state; slots beyond nnz read as zero.
  always_comb begin
    lhs_data = '0;
    lhs_col  = '0;
    for (int i = 0; i < N; i++) begin
      if ({1'b0, r_beat, LGN'(i)} < r_nnz) begin
        lhs_data[i] = r_store_data[{r_beat, LGN'(i)}];
        lhs_col[i]  = r_store_col[{r_beat, LGN'(i)}];
      end else begin
        lhs_data[i] = '0;
        lhs_col[i]  = '0;
      end
    end
  end

  assign row_ready = r_row_ready;
  assign lhs_valid = r_valid;
  assign lhs_start = r_start;
  assign lhs_last  = r_last;
  assign lhs_ptr   = r_ptr;
  assign lhs_nnz   = r_nnz;

endmodule

// File: tb/tb_csr_packer.sv
// Directed bench for csr_packer: known matrices, hand-derived CSR beats.
module tb_csr_packer;

  localparam int N = 16;
  localparam int W = 8;

  logic                clock;
  logic                reset;
  logic                row_valid;
  logic                row_ready;
  logic [N-1:0][W-1:0] row_data;
  logic                lhs_valid;
  logic                lhs_ready;
  logic                lhs_start;
  logic                lhs_last;
  logic [N-1:0][7:0]   lhs_ptr;
  logic [N-1:0][3:0]   lhs_col;
  logic [N-1:0][W-1:0] lhs_data;
  logic [8:0]          lhs_nnz;

  csr_packer #(.N(N), .W(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .lhs_valid (lhs_valid),
    .lhs_ready (lhs_ready),
    .lhs_start (lhs_start),
    .lhs_last  (lhs_last),
    .lhs_ptr   (lhs_ptr),
    .lhs_col   (lhs_col),
    .lhs_data  (lhs_data),
    .lhs_nnz   (lhs_nnz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  int unsigned m [N][N];
  int unsigned e_val [N*N];
  int unsigned e_col [N*N];
  int unsigned e_ptr [N];
  int unsigned e_nz;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_matrix(input int mode);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        case (mode)
          0: m[r][c] = (r == c) ? 1 : 0;
          1: m[r][c] = 0;
          2: m[r][c] = 3;
          3: m[r][c] = (r == 5 && (c == 2 || c == 9)) ? 20 : 0;
          default: m[r][c] = (((r * 7 + c * 3) % 5) == 0) ? (r + c + 1) : 0;
        endcase
      end
    // Reference CSR built straight from the dense matrix.
    e_nz = 0;
    for (int r = 0; r < N; r++) begin
      e_ptr[r] = e_nz;
      for (int c = 0; c < N; c++)
        if (m[r][c] != 0) begin
          e_val[e_nz] = m[r][c];
          e_col[e_nz] = c;
          e_nz++;
        end
    end
  endtask

  task automatic send_rows(input int nrows);
    int t;
    for (int r = 0; r < nrows; r++) begin
      if (r % 4 == 2) begin
        row_valid = 1'b0;
        for (int c = 0; c < N; c++) row_data[c] = 8'hFF;
        @(negedge clock);
      end
      row_valid = 1'b1;
      for (int c = 0; c < N; c++) row_data[c] = 8'(m[r][c]);
      t = 0;
      while (!row_ready && t < 50) begin
        @(negedge clock);
        t++;
      end
      if (t >= 50) check($sformatf("row_ready_timeout_r%0d", r), 128'(t), 128'(0));
      @(negedge clock);
    end
    row_valid = 1'b0;
    for (int c = 0; c < N; c++) row_data[c] = 8'h00;
  endtask

  task automatic check_beat(input int k, input int nb);
    logic [127:0] x_ptr;
    logic [127:0] x_data;
    logic [63:0]  x_col;
    int           idx;
    x_ptr = '0; x_data = '0; x_col = '0;
    for (int i = 0; i < N; i++) begin
      x_ptr[i*8 +: 8] = 8'(e_ptr[i]);
      idx = k * N + i;
      if (idx < int'(e_nz)) begin
        x_data[i*8 +: 8] = 8'(e_val[idx]);
        x_col[i*4 +: 4]  = 4'(e_col[idx]);
      end
    end
    check($sformatf("valid_b%0d", k), 128'(lhs_valid), 128'(1));
    check($sformatf("start_b%0d", k), 128'(lhs_start), 128'(k == 0));
    check($sformatf("last_b%0d", k), 128'(lhs_last), 128'(k == nb - 1));
    check($sformatf("nnz_b%0d", k), 128'(lhs_nnz), 128'(e_nz));
    check($sformatf("ptr_b%0d", k), 128'(lhs_ptr), x_ptr);
    check($sformatf("col_b%0d", k), 128'(lhs_col), 128'(x_col));
    check($sformatf("data_b%0d", k), 128'(lhs_data), x_data);
  endtask

  task automatic recv_matrix(input int stall_beat);
    int nb;
    int k;
    int t;
    nb = (e_nz == 0) ? 1 : int'((e_nz + N - 1) / N);
    check("valid_rise", 128'(lhs_valid), 128'(1));
    k = 0; t = 0;
    while (k < nb && t < 200) begin
      if (lhs_valid) begin
        check_beat(k, nb);
        if (k == stall_beat) begin
          lhs_ready = 1'b0;
          repeat (5) begin
            @(negedge clock);
            check_beat(k, nb);
            check("stall_row_ready", 128'(row_ready), 128'(0));
          end
          lhs_ready = 1'b1;
        end
        k++;
      end
      @(negedge clock);
      t++;
    end
    if (k < nb) check("beat_timeout", 128'(k), 128'(nb));
    check("done_valid", 128'(lhs_valid), 128'(0));
    check("done_row_ready", 128'(row_ready), 128'(1));
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_row_ready", 128'(row_ready), 128'(0));
    check("rst_valid", 128'(lhs_valid), 128'(0));
    check("rst_start", 128'(lhs_start), 128'(0));
    check("rst_last", 128'(lhs_last), 128'(0));
    check("rst_nnz", 128'(lhs_nnz), 128'(0));
    check("rst_ptr", 128'(lhs_ptr), 128'(0));
    reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    reset     = 1'b0;
    row_valid = 1'b0;
    lhs_ready = 1'b1;
    row_data  = '0;
    @(negedge clock);
    apply_reset();

    set_matrix(0); send_rows(N); recv_matrix(-1);   // identity
    set_matrix(1); send_rows(N); recv_matrix(-1);   // all zero
    set_matrix(2); send_rows(N); recv_matrix(1);    // dense, stall on beat 1
    set_matrix(3); send_rows(N); recv_matrix(-1);   // only row 5 populated
    set_matrix(4); send_rows(N); recv_matrix(0);    // scattered pattern

    set_matrix(2); send_rows(7);                    // partial matrix, then reset
    apply_reset();
    set_matrix(0); send_rows(N); recv_matrix(-1);   // identity, no residue

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/csr_packer.md
CSR_PACKER -- requirements
Module: csr_packer

Interface
REQ-001 SHALL take parameter N, default 16: matrix dimension and nonzeros per output beat (power of two, >=4).
REQ-002 SHALL take parameter W, default 8: element data width (data_t).
REQ-003 SHALL have ports: clock  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have ports: reset  in  1  synchronous, active-low (asserted when 0).
REQ-005 SHALL have ports: row_valid  in  1  dense row offered.
REQ-006 SHALL have ports: row_ready  out  1  packer accepts row.
REQ-007 SHALL have ports: row_data  in  N x data_t  dense row, element j = column j.
REQ-008 SHALL have ports: lhs_valid  out  1  CSR beat valid.
REQ-009 SHALL have ports: lhs_ready  in  1  consumer accepts beat.
REQ-010 SHALL have ports: lhs_start  out  1  first beat of matrix.
REQ-011 SHALL have ports: lhs_last  out  1  final beat of matrix.
REQ-012 SHALL have ports: lhs_ptr  out  N x 2*clog2(N)  row start offsets.
REQ-013 SHALL have ports: lhs_col  out  N x clog2(N)  column index per nonzero.
REQ-014 SHALL have ports: lhs_data  out  N x data_t  nonzero values.
REQ-015 SHALL have ports: lhs_nnz  out  2*clog2(N)+1  total nonzeros of matrix.

Function
REQ-016 SHALL implement two states, COLLECT and EMIT; reset enters COLLECT with row counter 0 and nnz counter 0.
REQ-017 SHALL drive row_ready=1 only in COLLECT; a row transfers when row_valid && row_ready.
REQ-018 SHALL, on each row transfer r, set ptr[r]=nnz count before the row, append the row's nonzeros (value != 0) in ascending column order to storage at that offset, and add the row's nonzero count.
REQ-019 SHALL hold storage for N*N entries (value plus column); row_valid gaps SHALL not alter state.
REQ-020 SHALL transition COLLECT->EMIT on the cycle row N-1 transfers; lhs_valid SHALL rise on the next cycle, with no combinational path from row_valid to lhs_*.
REQ-021 SHALL emit B = max(1, ceil(nnz/N)) beats; beat k carries storage entries k*N..k*N+N-1; slots >= nnz SHALL output data 0 and col 0.
REQ-022 SHALL hold lhs_ptr and lhs_nnz constant for all beats of a matrix.
REQ-023 SHALL assert lhs_start on beat 0 only and lhs_last on beat B-1 only; both on the same beat when B=1.
REQ-024 SHALL advance beats only when lhs_valid && lhs_ready; while lhs_ready=0 all lhs_* outputs SHALL stay stable.
REQ-025 SHALL, on transfer of the last beat, return to COLLECT with counters cleared; row_ready SHALL be 1 on the next cycle, and lhs_valid SHALL be 0 in that cycle.
REQ-026 SHALL drop lhs_valid, lhs_start and lhs_last to 0 in COLLECT; other lhs_* values are don't-care there.
REQ-027 SHALL use unsigned nnz arithmetic wide enough for N*N with no wrap; col index SHALL be the source column j.

Reset
REQ-028 SHALL, on any cycle with reset=0, force COLLECT, clear row and nnz counters, and drive row_ready=0, lhs_valid=0, lhs_start=0, lhs_last=0, lhs_nnz=0, lhs_ptr all 0.
REQ-029 SHALL discard any partial matrix or partially emitted beats on reset mid-operation; storage contents need not be cleared.

Structure
REQ-030 SHALL take N, W, lgN, dbLgN and data_t from shared package spmm_pkg, which the SpMM core also uses.
REQ-031 SHALL instantiate one combinational sub-module row_compactor: row_data -> compacted values, columns and nonzero count.

Verification
REQ-032 SHALL cover this N=16 case: identity matrix with value 1 -> one beat, start=last=1, ptr[r]=r, col[i]=i, data[i]=1, nnz=16.
REQ-033 SHALL cover this N=16 case: all-zero matrix -> one beat, ptr all 0, nnz=0, data all 0, start=last=1.
REQ-034 SHALL cover this N=16 case: dense matrix with all values 3 -> nnz=256, 16 beats, ptr[r]=16r, each beat col[i]=i, start on beat 0, last on beat 15.
REQ-035 SHALL cover this N=16 case: only row 5 has nonzeros, 20 at cols 2 and 9 -> ptr[0..5]=0, ptr[6..15]=2, beat slot0=(2,20), slot1=(9,20), nnz=2.
REQ-036 SHALL cover this N=16 case: lhs_ready held 0 for 5 cycles during beat 1 of the dense matrix -> beat-1 outputs stable, row_ready=0, stream resumes at beat 1.
REQ-037 SHALL cover this N=16 case: reset=0 after 7 rows accepted, then the identity matrix -> output identical to REQ-032 with no residue.
